// File: rtl/v_pkg.sv
// ============================================================================
// Module   : v_pkg
// Brief    : Shared types and helpers for the vector store bank writer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package v_pkg;

    localparam int NUM_BANKS = 4;

    typedef enum logic [0:0] {
        SBW_IDLE  = 1'b0,
        SBW_ISSUE = 1'b1
    } sbw_state_t;

    // Banks are word-interleaved on the two least significant address bits.
    function automatic logic [1:0] bank_sel(input logic [31:0] addr);
        return addr[1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/v_bank_grant.sv
// ============================================================================
// Module   : v_bank_grant
// Brief    : Per-bank lowest-lane arbitration over pending store lanes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module v_bank_grant
    import v_pkg::*;
(
    input  logic [NUM_BANKS-1:0]           pend_mask,
    input  logic [2*NUM_BANKS-1:0]         bank_sels,
    output logic [NUM_BANKS*NUM_BANKS-1:0] grant,
    output logic [NUM_BANKS-1:0]           grant_any,
    output logic [NUM_BANKS-1:0]           clear_mask
);

    localparam logic [NUM_BANKS-1:0] c_ONE = 1;

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [NUM_BANKS-1:0] w_hit;

            for (genvar i = 0; i < NUM_BANKS; i++) begin : g_lane
                assign w_hit[i] = pend_mask[i] && (bank_sels[2*i +: 2] == 2'(b));
            end

            // Isolate the lowest set bit so earlier lanes win.
            assign grant[b*NUM_BANKS +: NUM_BANKS] = w_hit & (~w_hit + c_ONE);
            assign grant_any[b]                    = |w_hit;
        end
    endgenerate

    always_comb begin
        clear_mask = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            clear_mask = clear_mask | grant[b*NUM_BANKS +: NUM_BANKS];
        end
    end

endmodule

`default_nettype wire

// File: rtl/v_store_bank_writer.sv
// ============================================================================
// Module   : v_store_bank_writer
// Brief    : Drives 4 word-interleaved data banks from one store beat,
//            serialising bank conflicts in lane order.
//            Optional macro STORE_BANK_PERF_EN adds perf_conflict_cnt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module v_store_bank_writer
    import v_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [LANES-1:0]           in_lane_en,
    input  logic [LANES*ADDR_W-1:0]    in_addr,
    input  logic [LANES*DATA_W-1:0]    in_data,
    output logic [LANES-1:0]           bank_we,
    output logic [LANES*(ADDR_W-2)-1:0] bank_addr,
    output logic [LANES*DATA_W-1:0]    bank_wdata,
    output logic                       done
`ifdef STORE_BANK_PERF_EN
    ,
    output logic [15:0]                perf_conflict_cnt
`endif
);

    localparam int c_ROW_W = ADDR_W - 2;

    sbw_state_t                r_state;
    sbw_state_t                w_state_nxt;
    logic [LANES-1:0]          r_pend_mask;
    logic [ADDR_W-1:0]         r_addr [LANES];
    logic [DATA_W-1:0]         r_data [LANES];
    logic                      r_last;
    logic                      r_done;

    logic [2*LANES-1:0]        w_sels;
    logic [LANES*LANES-1:0]    w_grant;
    logic [LANES-1:0]          w_grant_any;
    logic [LANES-1:0]          w_clear;
    logic [LANES-1:0]          w_pend_eff;
    logic                      w_retire;
    logic                      w_ready;
    logic                      w_accept;

    assign w_pend_eff = (r_state == SBW_ISSUE) ? r_pend_mask : '0;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_sel
            assign w_sels[2*i +: 2] = bank_sel(32'(r_addr[i]));
        end
    endgenerate

    v_bank_grant u_bank_grant (
        .pend_mask  (w_pend_eff),
        .bank_sels  (w_sels),
        .grant      (w_grant),
        .grant_any  (w_grant_any),
        .clear_mask (w_clear)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            SBW_IDLE: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = SBW_ISSUE;
                end
            end
            SBW_ISSUE: begin
                // Retire once nothing would remain after this cycle's grants.
                w_retire = ((r_pend_mask & ~w_clear) == '0);
                w_ready  = w_retire;
                if (w_retire) begin
                    w_state_nxt = in_valid ? SBW_ISSUE : SBW_IDLE;
                end
            end
            default: w_state_nxt = SBW_IDLE;
        endcase
    end

    assign w_accept = in_valid && w_ready;
    assign in_ready = w_ready && nrst;
    assign bank_we  = w_grant_any;
    assign done     = r_done;

    generate
        for (genvar b = 0; b < LANES; b++) begin : g_bank
            logic [c_ROW_W-1:0] w_row;
            logic [DATA_W-1:0]  w_wdata;

            always_comb begin
                w_row   = '0;
                w_wdata = '0;
                for (int i = 0; i < LANES; i++) begin
                    if (w_grant[b*LANES + i]) begin
                        w_row   = w_row | r_addr[i][ADDR_W-1:2];
                        w_wdata = w_wdata | r_data[i];
                    end
                end
            end

            assign bank_addr[b*c_ROW_W +: c_ROW_W] = w_row;
            assign bank_wdata[b*DATA_W +: DATA_W]  = w_wdata;
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= SBW_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pend_mask <= '0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_done <= w_retire && r_last;
            if (w_accept) begin
                r_pend_mask <= in_lane_en;
                r_last      <= in_last;
                for (int i = 0; i < LANES; i++) begin
                    r_addr[i] <= in_addr[i*ADDR_W +: ADDR_W];
                    r_data[i] <= in_data[i*DATA_W +: DATA_W];
                end
            end else if (r_state == SBW_ISSUE) begin
                r_pend_mask <= r_pend_mask & ~w_clear;
            end
        end
    end

`ifdef STORE_BANK_PERF_EN
    logic [15:0] r_perf_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_perf_cnt <= '0;
        end else if ((r_state == SBW_ISSUE) && !w_retire && (r_perf_cnt != 16'hFFFF)) begin
            r_perf_cnt <= r_perf_cnt + 16'd1;
        end
    end

    assign perf_conflict_cnt = r_perf_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_v_store_bank_writer.sv
// ============================================================================
// Module   : tb_v_store_bank_writer
// Brief    : Self-checking bench for v_store_bank_writer (per-bank queue model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_v_store_bank_writer;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int RW = AW - 2;

    logic              clk = 1'b0;
    logic              nrst;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        in_lane_en;
    logic [4*AW-1:0]   in_addr;
    logic [4*DW-1:0]   in_data;
    logic [3:0]        bank_we;
    logic [4*RW-1:0]   bank_addr;
    logic [4*DW-1:0]   bank_wdata;
    logic              done;
`ifdef STORE_BANK_PERF_EN
    logic [15:0]       perf_conflict_cnt;
`endif

    v_store_bank_writer #(.ADDR_W(AW), .DATA_W(DW), .LANES(4)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_lane_en (in_lane_en),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .done       (done)
`ifdef STORE_BANK_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: per-bank queues of pending lane indices, ascending lane order.
    int          mq [4][$];
    logic [AW-1:0] m_addr [4];
    logic [DW-1:0] m_data [4];
    bit          m_busy, m_last, m_done;
    int          m_perf;

    int          checks, errors;
    bit          acc_flag;
    bit          trk, trk_first;
    int          cap_occ;
    logic [3:0]  cap_we0;
    int          done_cnt, we_full_cnt, we_any_cnt;
    logic [31:0] dmem [int];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [3:0]    e_we;
        logic [4*RW-1:0] e_addr;
        logic [4*DW-1:0] e_wd;
        bit            e_ready, retire, w_acc;
        @(negedge clk);
        e_we = '0; e_addr = '0; e_wd = '0; retire = 1'b0; e_ready = 1'b0;
        if (!nrst) begin
            for (int b = 0; b < 4; b++) mq[b].delete();
            m_busy = 0; m_done = 0; m_perf = 0;
        end else begin
            if (m_busy) begin
                retire = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (mq[b].size() > 0) begin
                        int l;
                        l = mq[b][0];
                        e_we[b] = 1'b1;
                        e_addr[b*RW +: RW] = m_addr[l][AW-1:2];
                        e_wd[b*DW +: DW] = m_data[l];
                        if (mq[b].size() > 1) retire = 1'b0;
                    end
                end
            end
            e_ready = !m_busy || retire;
        end
        chk("in_ready", 128'(in_ready), 128'(e_ready));
        chk("bank_we", 128'(bank_we), 128'(e_we));
        chk("bank_addr", 128'(bank_addr), 128'(e_addr));
        chk("bank_wdata", 128'(bank_wdata), 128'(e_wd));
        chk("done", 128'(done), 128'(m_done));
`ifdef STORE_BANK_PERF_EN
        chk("perf_cnt", 128'(perf_conflict_cnt), 128'(m_perf));
`endif
        for (int b = 0; b < 4; b++) begin
            if (bank_we[b]) dmem[(int'(bank_addr[b*RW +: RW]) << 2) | b] = bank_wdata[b*DW +: DW];
        end
        if (done) done_cnt++;
        if (bank_we == 4'hF) we_full_cnt++;
        if (bank_we != 4'h0) we_any_cnt++;
        if (trk) begin
            cap_occ++;
            if (trk_first) cap_we0 = bank_we;
            trk_first = 0;
            if (in_ready) trk = 0;
        end
        w_acc = in_valid && e_ready && nrst;
        @(posedge clk);
        if (nrst) begin
            if (m_busy) begin
                if (!retire && m_perf != 16'hFFFF) m_perf++;
                for (int b = 0; b < 4; b++) if (mq[b].size() > 0) void'(mq[b].pop_front());
            end
            m_done = m_busy && retire && m_last;
            if (w_acc) begin
                for (int i = 0; i < 4; i++) begin
                    m_addr[i] = in_addr[i*AW +: AW];
                    m_data[i] = in_data[i*DW +: DW];
                    if (in_lane_en[i]) mq[int'(m_addr[i][1:0])].push_back(i);
                end
                m_last = in_last;
                m_busy = 1;
            end else if (m_busy && retire) begin
                m_busy = 0;
            end
        end
        acc_flag = w_acc;
        if (w_acc) begin
            trk = 1; trk_first = 1; cap_occ = 0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last = 1'($urandom);
        in_lane_en = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            in_addr[i*AW +: AW] = AW'($urandom);
            in_data[i*DW +: DW] = $urandom;
        end
        repeat (n) step();
    endtask

    task automatic send(input logic [3:0] en, input logic [4*AW-1:0] a,
                        input logic [4*DW-1:0] d, input logic last);
        bit ok;
        in_valid = 1'b1; in_lane_en = en; in_addr = a; in_data = d; in_last = last;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (acc_flag) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got not accepted expected accepted within 20 cycles");
        end
    endtask

    function automatic logic [4*AW-1:0] pa(input int a0, a1, a2, a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [4*DW-1:0] pd(input int d0, d1, d2, d3);
        return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    endfunction

    typedef struct {
        logic [3:0]      en;
        logic [4*AW-1:0] a;
        logic [4*DW-1:0] d;
        logic            last;
        int              occ;
        logic [3:0]      we0;
    } vec_t;

    vec_t vecs [7];

    initial begin
        checks = 0; errors = 0; m_perf = 0; m_busy = 0; m_done = 0; trk = 0;
        nrst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_lane_en = '0; in_addr = '0; in_data = '0;

        vecs[0] = '{4'hF, pa('h100,'h101,'h102,'h103), pd('hA0,'hA1,'hA2,'hA3), 1'b1, 1, 4'hF};
        vecs[1] = '{4'hF, pa('h10,'h14,'h18,'h1C), pd(11,12,13,14), 1'b0, 4, 4'h1};
        vecs[2] = '{4'hF, pa('h20,'h20,'h20,'h20), pd(1,2,3,4), 1'b1, 4, 4'h1};
        vecs[3] = '{4'b0101, pa('h31,'h31,'h33,'h33), pd(5,6,7,8), 1'b0, 1, 4'b1010};
        vecs[4] = '{4'h0, pa('h40,'h40,'h40,'h40), pd(0,0,0,0), 1'b1, 1, 4'h0};
        vecs[5] = '{4'hF, pa('h0,'h1,'h4,'h5), pd(21,22,23,24), 1'b1, 2, 4'h3};
        vecs[6] = '{4'hF, pa('h2,'h6,'hA,'h3), pd(31,32,33,34), 1'b0, 3, 4'hC};

        repeat (2) step();
        nrst = 1'b1;
        idle(2);

        for (int v = 0; v < 7; v++) begin
            send(vecs[v].en, vecs[v].a, vecs[v].d, vecs[v].last);
            idle(6);
            chk($sformatf("occupancy[%0d]", v), 128'(cap_occ), 128'(vecs[v].occ));
            chk($sformatf("first_we[%0d]", v), 128'(cap_we0), 128'(vecs[v].we0));
        end
        chk("mem_0x20", 128'(dmem.exists(32'h20) ? dmem[32'h20] : 32'hDEADBEEF), 128'(4));

        // Back-to-back unit-stride beats, last on the third.
        done_cnt = 0; we_full_cnt = 0;
        send(4'hF, pa('h200,'h201,'h202,'h203), pd(1,2,3,4), 1'b0);
        send(4'hF, pa('h204,'h205,'h206,'h207), pd(5,6,7,8), 1'b0);
        send(4'hF, pa('h208,'h209,'h20A,'h20B), pd(9,10,11,12), 1'b1);
        idle(5);
        chk("b2b_done_pulses", 128'(done_cnt), 128'(1));
        chk("b2b_write_cycles", 128'(we_full_cnt), 128'(3));

        // Reset during the second issue cycle of a full conflict.
        send(4'hF, pa('h10,'h14,'h18,'h1C), pd(41,42,43,44), 1'b1);
        in_valid = 1'b0;
        step();
        nrst = 1'b0;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_bank_we", 128'(bank_we), 128'(0));
        chk("rst_bank_addr", 128'(bank_addr), 128'(0));
        chk("rst_bank_wdata", 128'(bank_wdata), 128'(0));
        done_cnt = 0; we_any_cnt = 0;
        repeat (3) step();
        nrst = 1'b1;
        idle(5);
        chk("rst_no_done", 128'(done_cnt), 128'(0));
        chk("rst_no_writes", 128'(we_any_cnt), 128'(0));
        send(4'hF, pa('h300,'h301,'h302,'h303), pd(51,52,53,54), 1'b1);
        idle(3);

        // Randomized beats against the model.
        for (int n = 0; n < 200; n++) begin
            logic [4*AW-1:0] a;
            logic [4*DW-1:0] d;
            logic [AW-1:0]   base;
            int              mode;
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            mode = $urandom_range(0, 2);
            base = AW'($urandom);
            for (int i = 0; i < 4; i++) begin
                case (mode)
                    0:       a[i*AW +: AW] = base + AW'(i);
                    1:       a[i*AW +: AW] = AW'($urandom_range(0, 15));
                    default: a[i*AW +: AW] = AW'($urandom);
                endcase
                d[i*DW +: DW] = $urandom;
            end
            send(4'($urandom), a, d, 1'($urandom_range(0, 3) == 0));
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
